// File: rtl/tap_load_demux_pkg.sv
// Shared definitions for the tap load demux: FSM state encoding and tap-bank geometry.
package tap_load_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loadStateT;

    localparam int unsigned NUM_TAP  = 10;
    localparam logic [3:0]  LAST_IDX = 4'd9;

endpackage

// File: rtl/tap_load_demux_tap_reg_bank.sv
// Ten TAP_W-bit tap registers behind a single write port; each tap is a flop.
module tap_reg_bank
    import tap_load_demux_pkg::*;
#(
    parameter int unsigned TAP_W = 3
) (
    input  logic                            iClk,
    input  logic                            iRsn,
    input  logic                            iWrEn,
    input  logic [3:0]                      iWrIdx,
    input  logic [TAP_W-1:0]                iWrData,
    output logic [NUM_TAP-1:0][TAP_W-1:0]   oTaps
);

    // Indices 10..15 are silently dropped so the bank is safe against any caller.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            oTaps <= '0;
        end else if (iWrEn && (iWrIdx <= LAST_IDX)) begin
            oTaps[iWrIdx] <= iWrData;
        end
    end

endmodule

// File: rtl/tap_load_demux.sv
// Tap-code demux: direct indexed writes or a sequential load of taps 0..9.
// Optional sticky out-of-range flag enabled by defining TAP_LOAD_SELERR_EN.
module tap_load_demux
    import tap_load_demux_pkg::*;
#(
    parameter int unsigned TAP_W = 3
) (
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             iWrEn,
    input  logic [3:0]       iWrSel,
    input  logic [TAP_W-1:0] iTapData,
    input  logic             iLoadStart,
    input  logic             iTapValid,
    output logic [TAP_W-1:0] oTap_0,
    output logic [TAP_W-1:0] oTap_1,
    output logic [TAP_W-1:0] oTap_2,
    output logic [TAP_W-1:0] oTap_3,
    output logic [TAP_W-1:0] oTap_4,
    output logic [TAP_W-1:0] oTap_5,
    output logic [TAP_W-1:0] oTap_6,
    output logic [TAP_W-1:0] oTap_7,
    output logic [TAP_W-1:0] oTap_8,
    output logic [TAP_W-1:0] oTap_9,
    output logic             oLoadBusy,
    output logic             oLoadDone,
    output logic             oSelErr
);

    loadStateT                      stateQ, stateD;
    logic [3:0]                     idxQ, idxD;
    logic                           bankWrEn;
    logic [3:0]                     bankWrIdx;
    logic                           selErrSet, selErrClr;
    logic                           busyQ, doneQ;
    logic [NUM_TAP-1:0][TAP_W-1:0]  taps;

    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        bankWrEn  = 1'b0;
        bankWrIdx = iWrSel;
        selErrSet = 1'b0;
        selErrClr = 1'b0;
        case (stateQ)
            IDLE: begin
                if (iLoadStart) begin
                    stateD    = LOAD;
                    idxD      = '0;
                    selErrClr = 1'b1;
                end else if (iWrEn) begin
                    if (iWrSel <= LAST_IDX) bankWrEn  = 1'b1;
                    else                    selErrSet = 1'b1;
                end
            end
            LOAD: begin
                bankWrIdx = idxQ;
                if (iTapValid) begin
                    bankWrEn = 1'b1;
                    // Index parks at 9; leaving LOAD is what ends the sequence.
                    if (idxQ == LAST_IDX) stateD = DONE;
                    else                  idxD   = idxQ + 4'd1;
                end
            end
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            stateQ <= IDLE;
            idxQ   <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            busyQ  <= (stateD == LOAD);
            doneQ  <= (stateD == DONE);
        end
    end

`ifdef TAP_LOAD_SELERR_EN
    logic selErrQ;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)          selErrQ <= 1'b0;
        else if (selErrClr) selErrQ <= 1'b0;
        else if (selErrSet) selErrQ <= 1'b1;
    end

    assign oSelErr = selErrQ;
`else
    logic unusedSelErr;
    assign unusedSelErr = selErrSet | selErrClr;
    assign oSelErr      = 1'b0;
`endif

    tap_reg_bank #(
        .TAP_W (TAP_W)
    ) uBank (
        .iClk    (iClk),
        .iRsn    (iRsn),
        .iWrEn   (bankWrEn),
        .iWrIdx  (bankWrIdx),
        .iWrData (iTapData),
        .oTaps   (taps)
    );

    assign oTap_0    = taps[0];
    assign oTap_1    = taps[1];
    assign oTap_2    = taps[2];
    assign oTap_3    = taps[3];
    assign oTap_4    = taps[4];
    assign oTap_5    = taps[5];
    assign oTap_6    = taps[6];
    assign oTap_7    = taps[7];
    assign oTap_8    = taps[8];
    assign oTap_9    = taps[9];
    assign oLoadBusy = busyQ;
    assign oLoadDone = doneQ;

endmodule

// File: tb/tb_tap_load_demux.sv
// Self-checking bench for tap_load_demux: vector table, directed load sequences, random vs. model.
module tb_tap_load_demux;

`ifdef TAP_LOAD_SELERR_EN
    localparam bit SELERR = 1'b1;
`else
    localparam bit SELERR = 1'b0;
`endif

    logic       iClk = 1'b0;
    logic       iRsn = 1'b1;
    logic       iWrEn = 1'b0;
    logic [3:0] iWrSel = '0;
    logic [2:0] iTapData = '0;
    logic       iLoadStart = 1'b0;
    logic       iTapValid = 1'b0;
    logic [2:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9;
    logic       oLoadBusy, oLoadDone, oSelErr;
    logic [2:0] tapArr [10];

    int errors = 0;
    int checks = 0;
    int busySeen = 0;
    int doneSeen = 0;

    // Reference model: tap contents, position of an in-flight load (-1 = none),
    // completion pulse pending, and the sticky error flag.
    int mTap [10];
    int mPos;
    bit mDone;
    bit mErr;

    always #5 iClk = ~iClk;

    tap_load_demux #(
        .TAP_W (3)
    ) dut (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iWrEn      (iWrEn),
        .iWrSel     (iWrSel),
        .iTapData   (iTapData),
        .iLoadStart (iLoadStart),
        .iTapValid  (iTapValid),
        .oTap_0     (tap0),
        .oTap_1     (tap1),
        .oTap_2     (tap2),
        .oTap_3     (tap3),
        .oTap_4     (tap4),
        .oTap_5     (tap5),
        .oTap_6     (tap6),
        .oTap_7     (tap7),
        .oTap_8     (tap8),
        .oTap_9     (tap9),
        .oLoadBusy  (oLoadBusy),
        .oLoadDone  (oLoadDone),
        .oSelErr    (oSelErr)
    );

    assign tapArr[0] = tap0;
    assign tapArr[1] = tap1;
    assign tapArr[2] = tap2;
    assign tapArr[3] = tap3;
    assign tapArr[4] = tap4;
    assign tapArr[5] = tap5;
    assign tapArr[6] = tap6;
    assign tapArr[7] = tap7;
    assign tapArr[8] = tap8;
    assign tapArr[9] = tap9;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 10; i++) mTap[i] = 0;
        mPos  = -1;
        mDone = 1'b0;
        mErr  = 1'b0;
    endfunction

    function automatic void modelStep(input bit wrEn, input int sel, input int data,
                                      input bit ls, input bit v);
        bit doneNext = 1'b0;
        if (mPos >= 0) begin
            if (v) begin
                mTap[mPos] = data;
                if (mPos == 9) begin
                    mPos     = -1;
                    doneNext = 1'b1;
                end else begin
                    mPos = mPos + 1;
                end
            end
        end else if (!mDone) begin
            if (ls) begin
                mPos = 0;
                mErr = 1'b0;
            end else if (wrEn) begin
                if (sel <= 9) mTap[sel] = data;
                else if (SELERR) mErr = 1'b1;
            end
        end
        mDone = doneNext;
    endfunction

    task automatic checkModel();
        chk("busy", int'(oLoadBusy), int'(mPos >= 0));
        chk("done", int'(oLoadDone), int'(mDone));
        chk("selErr", int'(oSelErr), int'(mErr));
        for (int i = 0; i < 10; i++) chk($sformatf("tap%0d", i), int'(tapArr[i]), mTap[i]);
    endtask

    task automatic cycle(input bit wrEn, input int sel, input int data, input bit ls, input bit v);
        iWrEn      = wrEn;
        iWrSel     = sel[3:0];
        iTapData   = data[2:0];
        iLoadStart = ls;
        iTapValid  = v;
        @(posedge iClk);
        modelStep(wrEn, sel, data, ls, v);
        #1;
        if (oLoadBusy) busySeen++;
        if (oLoadDone) doneSeen++;
        checkModel();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_busy"}, int'(oLoadBusy), 0);
        chk({tag, "_done"}, int'(oLoadDone), 0);
        chk({tag, "_selErr"}, int'(oSelErr), 0);
        for (int i = 0; i < 10; i++) chk($sformatf("%s_tap%0d", tag, i), int'(tapArr[i]), 0);
    endtask

    task automatic doReset();
        iRsn = 1'b0;
        #1;
        checkAllZero("rst");
        modelReset();
        repeat (2) @(posedge iClk);
        #1;
        iRsn = 1'b1;
    endtask

    // Sequential load of the reference code list, optionally with a stall before every tap.
    task automatic runLoad(input bit stall, input string tag);
        int codes [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5};
        busySeen = 0;
        doneSeen = 0;
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (stall) cycle(1'b0, 0, 7, 1'b0, 1'b0);
            cycle(1'b0, 0, codes[k], 1'b0, 1'b1);
        end
        repeat (3) cycle(1'b0, 0, 0, 1'b0, 1'b0);
        chk({tag, "_busyCycles"}, busySeen, stall ? 20 : 10);
        chk({tag, "_donePulses"}, doneSeen, 1);
        for (int i = 0; i < 10; i++) chk($sformatf("%s_tap%0d", tag, i), int'(tapArr[i]), codes[i]);
    endtask

    typedef struct {
        bit wrEn;
        int sel;
        int data;
        bit ls;
        bit v;
        bit expBusy;
        bit expErr;
        int tapIdx;
        int expTap;
    } vecT;

    vecT vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4,  5, 1'b0, 1'b0, 1'b0, 1'b0,   4, 5};
        vecs[1] = '{1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0,   4, 5};
        vecs[2] = '{1'b1, 12, 7, 1'b0, 1'b0, 1'b0, SELERR, 4, 5};
        vecs[3] = '{1'b1, 9,  3, 1'b0, 1'b0, 1'b0, SELERR, 9, 3};
        vecs[4] = '{1'b1, 2,  6, 1'b1, 1'b0, 1'b1, 1'b0,   2, 0};
        vecs[5] = '{1'b0, 0,  0, 1'b0, 1'b0, 1'b1, 1'b0,   2, 0};
        vecs[6] = '{1'b0, 0,  1, 1'b0, 1'b1, 1'b1, 1'b0,   0, 1};
        vecs[7] = '{1'b1, 3,  7, 1'b1, 1'b0, 1'b1, 1'b0,   3, 0};
        vecs[8] = '{1'b0, 0,  2, 1'b0, 1'b1, 1'b1, 1'b0,   1, 2};

        modelReset();
        doReset();

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].wrEn, vecs[i].sel, vecs[i].data, vecs[i].ls, vecs[i].v);
            chk($sformatf("vec%0d_busy", i), int'(oLoadBusy), int'(vecs[i].expBusy));
            chk($sformatf("vec%0d_selErr", i), int'(oSelErr), int'(vecs[i].expErr));
            chk($sformatf("vec%0d_tap%0d", i, vecs[i].tapIdx), int'(tapArr[vecs[i].tapIdx]),
                vecs[i].expTap);
        end

        doReset();
        runLoad(1'b0, "load");
        doReset();
        runLoad(1'b1, "stall");

        // Reset asserted mid-load after five taps have been written.
        doReset();
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 0, k + 2, 1'b0, 1'b1);
        chk("midload_tap4_written", int'(tap4), 6);
        #2;
        iRsn = 1'b0;
        #1;
        checkAllZero("midrst");
        modelReset();
        repeat (2) @(posedge iClk);
        #1;
        chk("midrst_held_done", int'(oLoadDone), 0);
        chk("midrst_held_busy", int'(oLoadBusy), 0);
        iRsn = 1'b1;
        doneSeen = 0;
        repeat (3) cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("midrst_noDone", doneSeen, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tap_load_demux.md
TAP_LOAD_DEMUX -- requirements
Module: tap_load_demux

Interface
REQ-001 Parameter: TAP_W, default 3, width of each tap-delay code.
REQ-002 iClk  input  1  block clock; all state updates on its rising edge.
REQ-003 iRsn  input  1  asynchronous, active-low reset.
REQ-004 iWrEn  input  1  direct-write strobe.
REQ-005 iWrSel  input  4  direct-write tap index; legal range 0..9.
REQ-006 iTapData  input  TAP_W  tap code to be written.
REQ-007 iLoadStart  input  1  pulse that starts a sequential load of taps 0..9.
REQ-008 iTapValid  input  1  qualifies iTapData during a sequential load.
REQ-009 oTap_0 .. oTap_9  output  TAP_W each  registered tap codes, one port per tap.
REQ-010 oLoadBusy  output  1  high while a sequential load is in progress.
REQ-011 oLoadDone  output  1  one-cycle pulse at load completion.
REQ-012 oSelErr  output  1  sticky flag for an out-of-range direct-write index.

Function
REQ-013 The block SHALL hold ten TAP_W-bit tap registers, each driving oTap_N directly from a flop.
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-015 In IDLE, when iWrEn=1 and iWrSel<=9, the block SHALL write iTapData to tap[iWrSel]; the new value appears on oTap_N on the next cycle.
REQ-016 In IDLE, when iWrEn=1 and iWrSel>=10, no tap SHALL change.
REQ-017 In IDLE, iLoadStart=1 SHALL move the FSM to LOAD and clear the 4-bit index counter to 0.
REQ-018 If iLoadStart and iWrEn are both high in IDLE, iLoadStart SHALL win and the direct write SHALL be discarded.
REQ-019 In LOAD, each cycle with iTapValid=1 SHALL write iTapData to tap[index] and increment the index; a cycle with iTapValid=0 SHALL stall with no write.
REQ-020 When the write to index 9 occurs, the FSM SHALL go to DONE; the index SHALL NOT wrap to 0 or exceed 9.
REQ-021 DONE SHALL last exactly one cycle, with oLoadDone=1, and then return to IDLE.
REQ-022 oLoadBusy SHALL be 1 in LOAD only.
REQ-023 In LOAD, iWrEn and iLoadStart SHALL be ignored.
REQ-024 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-025 On iRsn=0, and regardless of the current state, including mid-load, the block SHALL return asynchronously to IDLE.
REQ-026 During reset the index SHALL be 0, all oTap_N SHALL be 0, and oLoadBusy, oLoadDone and oSelErr SHALL be 0.
REQ-027 Taps that a load interrupted by reset has already written SHALL also clear to 0.

Configuration
REQ-028 The macro TAP_LOAD_SELERR_EN SHALL control the error-flag feature.
REQ-029 With TAP_LOAD_SELERR_EN defined, oSelErr SHALL set on the cycle after an IDLE direct write with iWrSel>=10.
REQ-030 With TAP_LOAD_SELERR_EN defined, oSelErr SHALL stay set until reset or an accepted iLoadStart clears it.
REQ-031 With TAP_LOAD_SELERR_EN undefined, oSelErr SHALL be tied to 0, no error flop SHALL exist, and out-of-range writes SHALL still be ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2), NUM_TAP=10 and LAST_IDX=4'd9.
REQ-033 One sub-module, tap_reg_bank, SHALL contain the ten tap registers with a single write-enable, write-index and write-data port.
REQ-034 The FSM, the index counter and the error flag SHALL stay in the top module.

Verification
REQ-035 Direct write: after reset, iWrEn=1, iWrSel=4, iTapData=3'b101 -> oTap_4=5 on the next cycle, all other taps stay 0.
REQ-036 Sequential load: iLoadStart, then codes 0,1,..,7,6,5 on ten iTapValid cycles -> oTap_N matches in order, oLoadBusy is high for exactly 10 cycles, then oLoadDone pulses once.
REQ-037 Stalls: the REQ-036 load with iTapValid=0 on every second cycle -> same final taps, oLoadBusy high for 20 cycles, and oLoadDone pulses once.
REQ-038 Out-of-range write: iWrSel=12 with iWrEn=1 -> no tap changes; oSelErr=1 next cycle if TAP_LOAD_SELERR_EN is defined, else oSelErr stays 0; the next iLoadStart clears it.
REQ-039 Collision: iLoadStart and iWrEn with iWrSel=2 in the same cycle -> state goes to LOAD and oTap_2 is unchanged until the load writes it.
REQ-040 Reset mid-load: assert iRsn=0 after 5 loaded taps -> all taps are 0, the FSM is in IDLE and oLoadBusy=0 immediately, with no oLoadDone pulse.
